// File: rtl/tiny_fir_tap_streamer.sv
// -----------------------------------------------------------------------------
// tiny_fir_tap_streamer
//   Holds a small tap table written by the host and, on request, streams every
//   tap in address order to a FIR filter's tap input over a valid/ready
//   handshake. It then waits for the FIR to confirm programming, or times out.
//
//   Optional feature: define TINY_FIR_TAP_CHECKSUM_EN to accumulate the taps
//   that were handshaken and publish the sum on tap_checksum when a load ends.
//   When the macro is undefined, tap_checksum is tied to 0.
//
// Ports
//   clk            : clock, rising edge
//   reset_n        : synchronous active-low reset (tap memory is kept)
//   enable         : 0 acts like reset for everything except tap memory
//   cfg_addr/_data : host tap write address / value
//   cfg_wr         : host write strobe, honoured only while IDLE
//   load_start     : one-cycle request to stream all taps, honoured only in IDLE
//   tap_dout       : streamed tap value
//   tap_dout_valid : tap_dout is valid (held until tap_dout_ready)
//   tap_dout_ready : FIR accepts the tap
//   tap_dout_done  : FIR reports every tap programmed (used in WAIT_DONE only)
//   busy           : high in every state except IDLE
//   load_complete  : one-cycle pulse, load confirmed by tap_dout_done
//   load_error     : one-cycle pulse, tap_dout_done never arrived
//   tap_checksum   : sum of the taps sent in the last finished load
// -----------------------------------------------------------------------------
module tiny_fir_tap_streamer #(
  parameter int G_NUM_TAPS     = 16,
  parameter int G_TAP_WIDTH    = 16,
  parameter int G_DONE_TIMEOUT = 256
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      enable,
  input  logic [$clog2(G_NUM_TAPS)-1:0]             cfg_addr,
  input  logic [G_TAP_WIDTH-1:0]                    cfg_data,
  input  logic                                      cfg_wr,
  input  logic                                      load_start,
  output logic [G_TAP_WIDTH-1:0]                    tap_dout,
  output logic                                      tap_dout_valid,
  input  logic                                      tap_dout_ready,
  input  logic                                      tap_dout_done,
  output logic                                      busy,
  output logic                                      load_complete,
  output logic                                      load_error,
  output logic [G_TAP_WIDTH+$clog2(G_NUM_TAPS)-1:0] tap_checksum
);

  localparam int AW    = $clog2(G_NUM_TAPS);
  localparam int CSW   = G_TAP_WIDTH + AW;
  localparam int CNT_W = (G_DONE_TIMEOUT > 2) ? $clog2(G_DONE_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    SEND      = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [G_TAP_WIDTH-1:0] tap_q, tap_d;
  logic                   cmpl_q, cmpl_d;
  logic                   err_q, err_d;
  logic                   hs;

  logic [G_TAP_WIDTH-1:0] mem_q [G_NUM_TAPS];

  // Tap memory: no reset, so a reset or disable mid-load leaves taps intact.
  always_ff @(posedge clk) begin
    if (cfg_wr && state_q == IDLE)
      mem_q[cfg_addr] <= cfg_data;
  end

  assign hs = (state_q == SEND) && tap_dout_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tap_d   = tap_q;
    cmpl_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          idx_d   = '0;
          state_d = FETCH;
        end
      end
      // The read lands in tap_q at the end of FETCH: that register is the
      // memory's read-data register and also drives tap_dout during SEND.
      FETCH: begin
        tap_d   = mem_q[idx_q];
        state_d = SEND;
      end
      SEND: begin
        if (tap_dout_ready) begin
          if (idx_q == AW'(G_NUM_TAPS - 1)) begin
            cnt_d   = '0;
            state_d = WAIT_DONE;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = FETCH;
          end
        end
      end
      WAIT_DONE: begin
        // done is checked first so it wins on the last timeout cycle
        if (tap_dout_done) begin
          cmpl_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(G_DONE_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n || !enable) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      tap_q   <= '0;
      cmpl_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tap_q   <= tap_d;
      cmpl_q  <= cmpl_d;
      err_q   <= err_d;
    end
  end

`ifdef TINY_FIR_TAP_CHECKSUM_EN
  logic [CSW-1:0] acc_q, acc_d;
  logic [CSW-1:0] cks_q;

  always_comb begin
    acc_d = acc_q;
    if (state_q == IDLE && load_start) acc_d = '0;
    else if (hs)                       acc_d = acc_q + CSW'(tap_q);
  end

  // acc_q already holds the final tap by the time WAIT_DONE resolves.
  always_ff @(posedge clk) begin
    if (!reset_n || !enable) begin
      acc_q <= '0;
      cks_q <= '0;
    end else begin
      acc_q <= acc_d;
      if (cmpl_d || err_d) cks_q <= acc_q;
    end
  end

  assign tap_checksum = cks_q;
`else
  assign tap_checksum = '0;
`endif

  assign tap_dout       = tap_q;
  assign tap_dout_valid = (state_q == SEND);
  assign busy           = (state_q != IDLE);
  assign load_complete  = cmpl_q;
  assign load_error     = err_q;

endmodule

// File: tb/tb_tiny_fir_tap_streamer.sv
module tb_tiny_fir_tap_streamer;

  localparam int NT  = 16;
  localparam int TW  = 16;
  localparam int TO  = 256;
  localparam int AW  = $clog2(NT);
  localparam int CW  = TW + AW;

  logic          clk = 1'b0;
  logic          reset_n, enable;
  logic [AW-1:0] cfg_addr;
  logic [TW-1:0] cfg_data;
  logic          cfg_wr, load_start;
  logic [TW-1:0] tap_dout;
  logic          tap_dout_valid, tap_dout_ready, tap_dout_done;
  logic          busy, load_complete, load_error;
  logic [CW-1:0] tap_checksum;

  int checks = 0;
  int fails  = 0;

  // reference tap table, updated only by writes the host makes while idle
  logic [TW-1:0] mdl [NT];
  logic [CW-1:0] exp_cks;

  always #5 clk = ~clk;

  tiny_fir_tap_streamer #(
    .G_NUM_TAPS(NT), .G_TAP_WIDTH(TW), .G_DONE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_wr(cfg_wr),
    .load_start(load_start),
    .tap_dout(tap_dout), .tap_dout_valid(tap_dout_valid),
    .tap_dout_ready(tap_dout_ready), .tap_dout_done(tap_dout_done),
    .busy(busy), .load_complete(load_complete), .load_error(load_error),
    .tap_checksum(tap_checksum)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr_tap(input int a, input logic [TW-1:0] d);
    @(posedge clk); #1;
    cfg_wr = 1'b1; cfg_addr = AW'(a); cfg_data = d;
    mdl[a] = d;
    @(posedge clk); #1;
    cfg_wr = 1'b0;
  endtask

  // One load from IDLE.
  //   rdy_pct    : probability (percent) of ready each cycle
  //   done_dly   : done driven this many cycles after the last handshake cycle
  //                (-1 = never; TO = on the final timeout cycle)
  //   abort_mode : 0 none, 1 reset_n, 2 enable; applied after abort_tap taps
  //   poke       : cfg_wr addr 3 = FFFF plus load_start while busy
  //   wr_start   : new value for addr 0 written in the load_start cycle
  task automatic run_load(input int rdy_pct, input int done_dly, input int abort_mode,
                          input int abort_tap, input bit poke, input bit wr_start);
    logic [TW-1:0] got_q[$];
    logic [TW-1:0] prev_tap, wdat;
    logic [CW-1:0] sum;
    int  k_h, fb, cmpl_it, err_it, n_cmpl, n_err, abort_it, end_it;
    bit  stall_prev, fin, poked;
    k_h = -1; fb = -1; cmpl_it = -1; err_it = -1; n_cmpl = 0; n_err = 0;
    abort_it = -1; end_it = -1; stall_prev = 0; fin = 0; poked = 0;
    sum = '0; prev_tap = '0; wdat = TW'($urandom);
    for (int k = 0; k < 2000 && !fin; k++) begin
      @(posedge clk); #1;
      load_start = (k == 0);
      cfg_wr = 1'b0; tap_dout_done = 1'b0; reset_n = 1'b1; enable = 1'b1;
      if (k == 0 && wr_start) begin
        cfg_wr = 1'b1; cfg_addr = '0; cfg_data = wdat; mdl[0] = wdat;
      end
      tap_dout_ready = ($urandom_range(99) < rdy_pct);
      // stray done while streaming must be ignored
      if (k_h < 0 && k > 1 && $urandom_range(3) == 0) tap_dout_done = 1'b1;
      if (k_h >= 0 && done_dly >= 0 && k == k_h + done_dly) tap_dout_done = 1'b1;
      if (poke && !poked && got_q.size() == 2) begin
        poked = 1; cfg_wr = 1'b1; cfg_addr = AW'(3); cfg_data = 16'hFFFF; load_start = 1'b1;
      end
      if (abort_mode != 0 && abort_it < 0 && got_q.size() == abort_tap) begin
        abort_it = k;
        if (abort_mode == 1) reset_n = 1'b0; else enable = 1'b0;
      end

      @(negedge clk);
      if (fb < 0 && busy) fb = k;
      if (stall_prev) begin
        chk("hold_valid", tap_dout_valid, 1);
        chk("hold_data", tap_dout, prev_tap);
      end
      stall_prev = tap_dout_valid && !tap_dout_ready;
      prev_tap   = tap_dout;
      if (tap_dout_valid && tap_dout_ready) begin
        got_q.push_back(tap_dout);
        sum += CW'(tap_dout);
        if (got_q.size() == NT) k_h = k;
      end
      if (load_complete) begin n_cmpl++; cmpl_it = k; end
      if (load_error)    begin n_err++;  err_it  = k; end
      if ((load_complete || load_error) && end_it < 0) begin
        chk("idle_at_pulse", busy, 0);
        end_it = k + 2;
      end
      if (done_dly < 0 && k_h >= 0 && k == k_h + TO) chk("to_busy_hi", busy, 1);
      if (abort_it >= 0 && k == abort_it + 1) begin
        chk("abort_valid", tap_dout_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_dout", tap_dout, 0);
        chk("abort_cks", tap_checksum, 0);
        end_it = k + 3;
      end
      if (k == end_it) fin = 1;
    end
    tap_dout_ready = 1'b0; tap_dout_done = 1'b0; cfg_wr = 1'b0; load_start = 1'b0;
    reset_n = 1'b1; enable = 1'b1;

    chk("load_finished", fin, 1);
    chk("start_lat", fb, 1);
    if (abort_mode != 0) begin
      chk("abort_pulses", n_cmpl + n_err, 0);
      chk("abort_ntaps", got_q.size(), abort_tap);
      for (int i = 0; i < got_q.size() && i < NT; i++) chk("abort_tap", got_q[i], mdl[i]);
      exp_cks = '0;
    end else begin
      chk("ntaps", got_q.size(), NT);
      for (int i = 0; i < got_q.size() && i < NT; i++) chk("tap_seq", got_q[i], mdl[i]);
      if (rdy_pct == 100) chk("stream_cycles", k_h - fb + 1, 2 * NT);
      if (done_dly < 0) begin
        chk("err_cnt", n_err, 1);
        chk("cmpl_cnt", n_cmpl, 0);
        chk("err_time", err_it, k_h + 1 + TO);
      end else begin
        chk("cmpl_cnt", n_cmpl, 1);
        chk("err_cnt", n_err, 0);
        chk("cmpl_time", cmpl_it, k_h + done_dly + 1);
      end
`ifdef TINY_FIR_TAP_CHECKSUM_EN
      exp_cks = sum;
`else
      exp_cks = '0;
`endif
    end
    chk("checksum", tap_checksum, exp_cks);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; cfg_addr = '0; cfg_data = '0; cfg_wr = 1'b0;
    load_start = 1'b0; tap_dout_ready = 1'b0; tap_dout_done = 1'b0;
    exp_cks = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", tap_dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmpl", load_complete, 0);
    chk("rst_err", load_error, 0);
    chk("rst_dout", tap_dout, 0);
    chk("rst_cks", tap_checksum, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < NT; i++) wr_tap(i, TW'(i + 1));
    run_load(100, 3, 0, 0, 0, 0);
`ifdef TINY_FIR_TAP_CHECKSUM_EN
    chk("cks_0x88", tap_checksum, 'h88);
`endif
    run_load(50, 3 + $urandom_range(5), 0, 0, 0, 0);
    run_load(60, 3, 0, 0, 1, 0);        // write and load_start while busy ignored
    chk("tap3_kept", mdl[3], 16'h0004);
    run_load(50, 4, 0, 0, 0, 0);
    run_load(100, 3, 1, 5, 0, 0);       // reset after the 5th tap
    run_load(100, 3, 0, 0, 0, 0);       // original taps still there
    run_load(100, -1, 0, 0, 0, 0);      // no done -> timeout
    run_load(70, TO, 0, 0, 0, 0);       // done on the last timeout cycle

    for (int i = 0; i < NT; i++) wr_tap(i, TW'($urandom));
    run_load(50, 2, 2, $urandom_range(1, 14), 0, 1);  // disable mid-load
    run_load(70, 2, 0, 0, 0, 1);
    run_load(40, 1 + $urandom_range(9), 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
